// File: rtl/ikaopll_pkg.sv
// Shared types and defaults for the OPLL bus writer: FSM state encoding,
// bus payload struct and default phase lengths.
package ikaopll_pkg;

    localparam int unsigned CNT_W          = 8;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned ADDR_WAIT_DEF  = 12;
    localparam int unsigned DATA_WAIT_DEF  = 84;
    localparam int unsigned STROBE_LEN_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_WAIT,
        D_SETUP,
        D_STROBE,
        D_WAIT
    } state_t;

    typedef struct packed {
        logic              cs_n;
        logic              wr_n;
        logic              a0;
        logic [DATA_W-1:0] d;
    } bus_t;

    // Phase length in enables to counter reload value; a length of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] len_m1(input int unsigned n);
        if (n == 0) begin
            return '0;
        end
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/ikaopll_buswr_timer.sv
// Loadable 8-bit down-counter that only moves on phiM enable clocks; zero_c
// flags the last enable of the current phase.
module ikaopll_buswr_timer
    import ikaopll_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    // Load wins over decrement so a phase always starts from its full length.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/ikaopll_buswr.sv
// OPLL register write sequencer: turns a valid/ready request into an address
// phase and a data phase on the chip bus, paced by the phiM clock enable.
module ikaopll_buswr
    import ikaopll_pkg::*;
#(
    parameter int unsigned ADDR_WAIT  = ADDR_WAIT_DEF,
    parameter int unsigned DATA_WAIT  = DATA_WAIT_DEF,
    parameter int unsigned STROBE_LEN = STROBE_LEN_DEF,
    parameter int unsigned ADDR_CACHE = 1
) (
    input  logic              i_EMUCLK,
    input  logic              i_RST,
    input  logic              i_phiM_PCEN_n,
    input  logic              i_REQ_VALID,
    output logic              o_REQ_READY,
    input  logic [DATA_W-1:0] i_REQ_ADDR,
    input  logic [DATA_W-1:0] i_REQ_DATA,
    output logic              o_CS_n,
    output logic              o_WR_n,
    output logic              o_A0,
    output logic [DATA_W-1:0] o_D,
    output logic              o_BUSY,
    output logic              o_DONE
);

    localparam logic [CNT_W-1:0] STRB_M1  = len_m1(STROBE_LEN);
    localparam logic [CNT_W-1:0] AWAIT_M1 = len_m1(ADDR_WAIT);
    localparam logic [CNT_W-1:0] DWAIT_M1 = len_m1(DATA_WAIT);

    state_t            state;
    state_t            state_nxt;
    bus_t              bus_q;
    bus_t              bus_nxt;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [DATA_W-1:0] cache_addr;
    logic              cache_valid;
    logic              cache_hit;
    logic              cache_set;
    logic              accept;
    logic              step;
    logic              zero_c;
    logic              load;
    logic [CNT_W-1:0]  load_val;
    logic              done_nxt;

    ikaopll_buswr_timer u_timer (
        .clk      (i_EMUCLK),
        .rst      (i_RST),
        .en       (~i_phiM_PCEN_n),
        .load     (load),
        .load_val (load_val),
        .zero_c   (zero_c)
    );

    assign step      = ~i_phiM_PCEN_n & zero_c;
    assign cache_hit = (ADDR_CACHE != 0) && cache_valid && (cache_addr == i_REQ_ADDR);

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter reload and next bus values; bus is registered below.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cache_set = 1'b0;
        load_val  = '0;
        bus_nxt   = bus_q;
        case (state)
            IDLE: begin
                if (i_REQ_VALID && o_REQ_READY) begin
                    accept    = 1'b1;
                    state_nxt = cache_hit ? D_SETUP : A_SETUP;
                end
            end
            A_SETUP:  if (step) state_nxt = A_STROBE;
            A_STROBE: begin
                if (step) begin
                    state_nxt = A_WAIT;
                    cache_set = 1'b1;
                end
            end
            A_WAIT:   if (step) state_nxt = D_SETUP;
            D_SETUP:  if (step) state_nxt = D_STROBE;
            D_STROBE: if (step) state_nxt = D_WAIT;
            D_WAIT:   if (step) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase

        load     = accept || (state_nxt != state);
        addr_nxt = accept ? i_REQ_ADDR : addr_q;
        data_nxt = accept ? i_REQ_DATA : data_q;
        done_nxt = (state == D_WAIT) && (state_nxt == IDLE);

        case (state_nxt)
            A_STROBE, D_STROBE: load_val = STRB_M1;
            A_WAIT:             load_val = AWAIT_M1;
            D_WAIT:             load_val = DWAIT_M1;
            default:            load_val = '0;
        endcase

        // Idle and wait phases release the bus but keep A0/D where they were.
        bus_nxt.cs_n = 1'b1;
        bus_nxt.wr_n = 1'b1;
        case (state_nxt)
            A_SETUP:  begin bus_nxt.cs_n = 1'b0; bus_nxt.a0 = 1'b0; bus_nxt.d = addr_nxt; end
            A_STROBE: begin bus_nxt.cs_n = 1'b0; bus_nxt.wr_n = 1'b0; bus_nxt.a0 = 1'b0; bus_nxt.d = addr_nxt; end
            A_WAIT:   begin bus_nxt.a0 = 1'b0; bus_nxt.d = addr_nxt; end
            D_SETUP:  begin bus_nxt.cs_n = 1'b0; bus_nxt.a0 = 1'b1; bus_nxt.d = data_nxt; end
            D_STROBE: begin bus_nxt.cs_n = 1'b0; bus_nxt.wr_n = 1'b0; bus_nxt.a0 = 1'b1; bus_nxt.d = data_nxt; end
            D_WAIT:   begin bus_nxt.a0 = 1'b1; bus_nxt.d = data_nxt; end
            default:  ;
        endcase
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            bus_q       <= '{cs_n: 1'b1, wr_n: 1'b1, a0: 1'b0, d: '0};
            addr_q      <= '0;
            data_q      <= '0;
            cache_addr  <= '0;
            cache_valid <= 1'b0;
            o_BUSY      <= 1'b0;
            o_DONE      <= 1'b0;
            o_REQ_READY <= 1'b0;
        end else begin
            bus_q       <= bus_nxt;
            addr_q      <= addr_nxt;
            data_q      <= data_nxt;
            o_BUSY      <= (state_nxt != IDLE);
            o_DONE      <= done_nxt;
            o_REQ_READY <= (state_nxt == IDLE);
            if (cache_set) begin
                cache_addr  <= addr_q;
                cache_valid <= 1'b1;
            end
        end
    end

    assign o_CS_n = bus_q.cs_n;
    assign o_WR_n = bus_q.wr_n;
    assign o_A0   = bus_q.a0;
    assign o_D    = bus_q.d;

endmodule

// File: tb/tb_ikaopll_buswr.sv
// Directed bench for ikaopll_buswr: vector table of full/cached writes plus
// hand sequences for hold-valid, enable freeze, mid-transaction reset and zero-length phases.
module tb_ikaopll_buswr;

    logic       clk = 1'b0;
    logic       rst;
    logic       pcen_n;
    logic       valid;
    logic       valid2;
    logic [7:0] addr;
    logic [7:0] data;

    logic       ready, cs_n, wr_n, a0, busy, done;
    logic [7:0] d;
    logic       ready2, cs_n2, wr_n2, a02, busy2, done2;
    logic [7:0] d2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mode     = 0;   // 0: enable every 4th clock, 1: always enabled, 2: frozen

    always #5 clk = ~clk;

    ikaopll_buswr dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phiM_PCEN_n (pcen_n),
        .i_REQ_VALID   (valid),
        .o_REQ_READY   (ready),
        .i_REQ_ADDR    (addr),
        .i_REQ_DATA    (data),
        .o_CS_n        (cs_n),
        .o_WR_n        (wr_n),
        .o_A0          (a0),
        .o_D           (d),
        .o_BUSY        (busy),
        .o_DONE        (done)
    );

    ikaopll_buswr #(.ADDR_WAIT(0), .DATA_WAIT(0), .STROBE_LEN(0), .ADDR_CACHE(1)) dut2 (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phiM_PCEN_n (pcen_n),
        .i_REQ_VALID   (valid2),
        .o_REQ_READY   (ready2),
        .i_REQ_ADDR    (addr),
        .i_REQ_DATA    (data),
        .o_CS_n        (cs_n2),
        .o_WR_n        (wr_n2),
        .o_A0          (a02),
        .o_D           (d2),
        .o_BUSY        (busy2),
        .o_DONE        (done2)
    );

    // phiM enable generator; changes 1 time unit after each rising edge
    initial begin
        pcen_n = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (mode)
                0:       pcen_n = ((cyc % 4) != 0);
                1:       pcen_n = 1'b0;
                default: pcen_n = 1'b1;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_aligned_ready(input bit second);
        int tmo = 0;
        while (!(((second ? ready2 : ready) === 1'b1) && pcen_n === 1'b0) && tmo < 200) begin
            @(posedge clk); #2;
            tmo++;
        end
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] dd, input int exp_en,
                           input int exp_aen, input int exp_den, input int exp_clk,
                           input bit do_freeze, input bit keep,
                           input logic [7:0] na, input logic [7:0] nd, input string nm);
        int en = 0, clks = 0, aen = 0, den = 0, bad = 0, frz = 0;
        logic pw, pa;
        logic [7:0] pd;
        bit got = 0, frz_done = 0;
        wait_aligned_ready(1'b0);
        check({nm, "_ready"}, int'(ready), 1);
        valid = 1'b1; addr = a; data = dd;
        @(posedge clk); #2;
        if (keep) begin addr = na; data = nd; end
        else valid = 1'b0;
        check({nm, "_busy"}, int'(busy), 1);
        pw = wr_n; pa = a0; pd = d;
        while (!got && clks < 3000) begin
            @(posedge clk);
            clks++;
            if (pcen_n == 1'b0) begin
                en++;
                if (!pw && !pa) aen++;
                if (!pw && pa) den++;
                if (!pw && pd != (pa ? dd : a)) bad++;
            end
            #2;
            if (done) got = 1;
            if (do_freeze && !frz_done && mode != 2 && !wr_n && !a0) begin
                mode = 2;
            end else if (mode == 2) begin
                frz++;
                if (wr_n !== 1'b0) bad++;
                if (frz == 50) begin mode = 0; frz_done = 1; end
            end
            pw = wr_n; pa = a0; pd = d;
        end
        check({nm, "_done_seen"}, int'(got), 1);
        check({nm, "_enables"}, en, exp_en);
        check({nm, "_a_strobe_en"}, aen, exp_aen);
        check({nm, "_d_strobe_en"}, den, exp_den);
        check({nm, "_strobe_bus"}, bad, 0);
        if (do_freeze) check({nm, "_froze"}, int'(frz_done), 1);
        if (exp_clk >= 0) check({nm, "_clocks"}, clks, exp_clk);
        @(posedge clk); #2;
        check({nm, "_done_width"}, int'(done), 0);
        if (keep) begin
            valid = 1'b0;
            check({nm, "_next_accept"}, int'({busy, cs_n, a0, d}), int'({1'b1, 1'b0, 1'b0, na}));
        end else begin
            check({nm, "_ready_after"}, int'(ready), 1);
        end
    endtask

    task automatic wait_done(input string nm);
        int tmo = 0;
        bit got = 0;
        while (!got && tmo < 3000) begin
            @(posedge clk); #2;
            tmo++;
            if (done) got = 1;
        end
        check({nm, "_done_seen"}, int'(got), 1);
    endtask

    task automatic run2(input logic [7:0] a, input int exp_en, input string nm);
        int en = 0, clks = 0;
        bit got = 0;
        wait_aligned_ready(1'b1);
        valid2 = 1'b1; addr = a; data = 8'h5A;
        @(posedge clk); #2;
        valid2 = 1'b0;
        while (!got && clks < 200) begin
            @(posedge clk);
            clks++;
            if (pcen_n == 1'b0) en++;
            #2;
            if (done2) got = 1;
        end
        check({nm, "_done_seen"}, int'(got), 1);
        check({nm, "_enables"}, en, exp_en);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         en;
        int         aen;
        int         den;
        int         clks;
    } vec_t;

    vec_t vt[5];

    initial begin
        int ndone;
        vt[0] = '{8'h10, 8'h55, 102, 2, 2, 408};
        vt[1] = '{8'h10, 8'hAA,  87, 0, 2, 348};
        vt[2] = '{8'h20, 8'h01, 102, 2, 2, 408};
        vt[3] = '{8'h20, 8'h7F,  87, 0, 2, 348};
        vt[4] = '{8'h10, 8'h00, 102, 2, 2, 408};

        rst = 1'b1; valid = 1'b0; valid2 = 1'b0; addr = 8'h00; data = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("reset_bus", int'({cs_n, wr_n, a0, d, busy, done, ready}),
              int'({1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
        check("reset_bus2", int'({cs_n2, wr_n2, a02, d2, busy2, done2, ready2}),
              int'({1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        @(posedge clk); #2;
        check("ready_after_reset", int'(ready), 1);

        for (int i = 0; i < 5; i++) begin
            run_txn(vt[i].a, vt[i].d, vt[i].en, vt[i].aen, vt[i].den, vt[i].clks,
                    1'b0, 1'b0, 8'h00, 8'h00, $sformatf("vec%0d", i));
        end

        run_txn(8'h40, 8'h3C, 102, 2, 2, -1, 1'b1, 1'b0, 8'h00, 8'h00, "freeze");

        run_txn(8'h50, 8'h33, 102, 2, 2, 408, 1'b0, 1'b1, 8'h60, 8'h44, "hold_valid");
        wait_done("hold_valid_second");

        // Reset while the address phase is in its bus-idle wait
        wait_aligned_ready(1'b0);
        valid = 1'b1; addr = 8'h70; data = 8'h01;
        @(posedge clk); #2;
        valid = 1'b0;
        for (int t = 0; t < 200 && !(cs_n && busy); t++) begin
            @(posedge clk); #2;
        end
        check("rst_reached_a_wait", int'({cs_n, wr_n, busy, a0}), int'({1'b1, 1'b1, 1'b1, 1'b0}));
        rst = 1'b1;
        @(posedge clk); #2;
        check("rst_mid_bus", int'({cs_n, wr_n, a0, d, busy, done, ready}),
              int'({1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
        rst = 1'b0;
        @(posedge clk); #2;
        check("rst_mid_ready", int'(ready), 1);
        ndone = 0;
        repeat (150) begin
            @(posedge clk); #2;
            if (done) ndone++;
        end
        check("rst_mid_no_done", ndone, 0);
        run_txn(8'h70, 8'h02, 102, 2, 2, 408, 1'b0, 1'b0, 8'h00, 8'h00, "after_rst");

        run2(8'h11, 6, "zero_len_full");
        run2(8'h11, 3, "zero_len_hit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
